ula_unit: RTL and testbench

- 4-bit registered arithmetic/logic unit (ULA) for the datapath lab.
- Two operands and a 2-bit opcode are captured on a clock edge.
- Produces a result and a single status flag one cycle later.
- Sits between operand registers and the writeback/status path.

---
 rtl/ula_unit.sv | 63 ++++++
 tb/tb_ula_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ula_unit.sv
// Registered 4-bit ALU: ADD/SUB/AND/OR with carry, borrow or zero flag.
// One-cycle latency, accepts a new operation every cycle, no backpressure.
module ula_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] resul,
  output logic             flag,
  output logic             out_valid
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_next;
  logic             flag_next;

  // Widened by one bit so the top bit carries the carry (ADD) or borrow (SUB).
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    res_next  = '0;
    flag_next = 1'b0;
    case (sel)
      2'b00: begin
        res_next  = sum[WIDTH-1:0];
        flag_next = sum[WIDTH];
      end
      2'b01: begin
        res_next  = diff[WIDTH-1:0];
        flag_next = diff[WIDTH];
      end
      2'b10: begin
        res_next  = A & B;
        flag_next = ~|(A & B);
      end
      default: begin
        res_next  = A | B;
        flag_next = ~|(A | B);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resul     <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        resul <= res_next;
        flag  <= flag_next;
      end
    end
  end

endmodule

// File: tb/tb_ula_unit.sv
// Directed and random checks of ula_unit against an integer-arithmetic model.
module tb_ula_unit;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic [1:0]   sel;
  logic [W-1:0] resul;
  logic         flag;
  logic         out_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_res;
  logic         exp_flag;
  logic         exp_vld;

  ula_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .sel(sel),
    .resul(resul), .flag(flag), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".resul"}, {4'b0, resul}, {4'b0, exp_res});
    check({tag, ".flag"}, {7'b0, flag}, {7'b0, exp_flag});
    check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, exp_vld});
  endtask

  // Reference: arithmetic on plain integers, results folded into W bits.
  task automatic model(input int a, input int b, input int s);
    int r;
    case (s)
      0: begin r = a + b; exp_flag = (r >= MOD); r = r % MOD; end
      1: begin exp_flag = (a < b); r = (a - b + MOD) % MOD; end
      2: begin r = a & b; exp_flag = (r == 0); end
      default: begin r = a | b; exp_flag = (r == 0); end
    endcase
    exp_res = r[W-1:0];
  endtask

  task automatic apply(input string tag, input logic v, input int a, input int b, input int s);
    in_valid = v;
    A = a[W-1:0];
    B = b[W-1:0];
    sel = s[1:0];
    @(posedge clk);
    #1;
    if (v) model(a, b, s);
    exp_vld = v;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; sel = '0;
    exp_res = '0; exp_flag = 1'b0; exp_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    apply("pre_op", 1'b1, 4'b1001, 4'b0011, 0);
    // asynchronous reset asserted mid-cycle clears outputs at once
    #2 rst_n = 1'b0;
    #1;
    exp_res = '0; exp_flag = 1'b0; exp_vld = 1'b0;
    check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset_idle", 1'b0, 0, 0, 0);

    apply("sub_basic", 1'b1, 4'b0111, 4'b0110, 1);
    check("sub_basic.lit", {4'b0, resul}, 8'h01);
    apply("add_carry", 1'b1, 4'b1111, 4'b0001, 0);
    check("add_carry.flag_lit", {7'b0, flag}, 8'h01);
    apply("add_plain", 1'b1, 4'b0011, 4'b0100, 0);
    check("add_plain.lit", {4'b0, resul}, 8'h07);
    apply("sub_borrow", 1'b1, 4'b0010, 4'b0101, 1);
    check("sub_borrow.lit", {4'b0, resul}, 8'h0d);
    apply("sub_equal", 1'b1, 4'b1011, 4'b1011, 1);
    apply("and_zero", 1'b1, 4'b1010, 4'b0101, 2);
    check("and_zero.flag_lit", {7'b0, flag}, 8'h01);
    apply("or_full", 1'b1, 4'b1010, 4'b0101, 3);
    check("or_full.lit", {4'b0, resul}, 8'h0f);
    apply("or_zero", 1'b1, 0, 0, 3);
    apply("b2b_add", 1'b1, 4'b1100, 4'b0110, 0);
    apply("b2b_sub", 1'b1, 4'b0100, 4'b1001, 1);
    apply("hold", 1'b0, 4'b1111, 4'b1111, 0);
    check("hold.lit", {4'b0, resul}, 8'h0b);

    // unknown operands/select are ignored while in_valid is low
    in_valid = 1'b0; A = 'x; B = 'x; sel = 'x;
    @(posedge clk);
    #1;
    exp_vld = 1'b0;
    check_all("hold_x_sel");
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      apply("random", ($urandom_range(0, 3) != 0), $urandom_range(0, MOD - 1),
            $urandom_range(0, MOD - 1), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
